// File: rtl/axil_acc_ctrl.sv
// AXI-Lite control/argument register bank for one accelerator tile.
// Decodes a CTRL register (start/done/busy) and NREGS byte-writable argument registers.
module axil_acc_ctrl #(
    parameter int NREGS = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_axil_awvalid,
    output logic                 s_axil_awready,
    input  logic [31:0]          s_axil_awaddr,
    input  logic                 s_axil_wvalid,
    output logic                 s_axil_wready,
    input  logic [31:0]          s_axil_wdata,
    input  logic [3:0]           s_axil_wstrb,
    output logic                 s_axil_bvalid,
    input  logic                 s_axil_bready,
    output logic [1:0]           s_axil_bresp,
    input  logic                 s_axil_arvalid,
    output logic                 s_axil_arready,
    input  logic [31:0]          s_axil_araddr,
    output logic                 s_axil_rvalid,
    input  logic                 s_axil_rready,
    output logic [31:0]          s_axil_rdata,
    output logic [1:0]           s_axil_rresp,
    output logic                 acc_start,
    input  logic                 acc_done,
    output logic [32*NREGS-1:0]  acc_args
);
    typedef enum logic [1:0] {K_RSVD, K_CTRL, K_ARG, K_BAD} kind_e;
    localparam int ARG_BASE = 4;

    function automatic kind_e decode(input logic [9:0] idx);
        kind_e k;
        if (idx == 10'd0)                                           k = K_RSVD;
        else if (idx == 10'd1)                                      k = K_CTRL;
        else if (int'(idx) >= ARG_BASE && int'(idx) < ARG_BASE + NREGS) k = K_ARG;
        else                                                        k = K_BAD;
        return k;
    endfunction

    logic                    aw_held, w_held;
    logic [9:0]              aw_idx;
    logic [31:0]             w_data;
    logic [3:0]              w_strb;
    logic                    busy, done;
    logic [NREGS-1:0][31:0]  args;
    logic [31:0]             rd_data;
    kind_e                   wr_kind, rd_kind;
    logic                    aw_hs, w_hs, ar_hs, commit, start_req;
    logic [9:0]              ar_idx;

    assign s_axil_awready = !aw_held && !s_axil_bvalid;
    assign s_axil_wready  = !w_held && !s_axil_bvalid;
    assign s_axil_arready = !s_axil_rvalid;

    assign aw_hs   = s_axil_awvalid && s_axil_awready;
    assign w_hs    = s_axil_wvalid && s_axil_wready;
    assign ar_hs   = s_axil_arvalid && s_axil_arready;
    assign ar_idx  = s_axil_araddr[11:2];
    assign commit  = aw_held && w_held;
    assign wr_kind = decode(aw_idx);
    assign rd_kind = decode(ar_idx);

    // A start while busy is acknowledged but has no effect on the core.
    assign start_req = commit && wr_kind == K_CTRL && w_strb[0] && w_data[0] && !busy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= 2'b00;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= 2'b00;
            acc_start     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axil_awaddr[11:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= (wr_kind == K_BAD) ? 2'b10 : 2'b00;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end

            if (ar_hs) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_data;
                s_axil_rresp  <= (rd_kind == K_BAD) ? 2'b10 : 2'b00;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end

            acc_start <= start_req;
            if (start_req)     busy <= 1'b1;
            else if (acc_done) busy <= 1'b0;
            // A completion arriving with a CTRL read must not be lost to read-to-clear.
            if (acc_done)                         done <= 1'b1;
            else if (start_req)                   done <= 1'b0;
            else if (ar_hs && rd_kind == K_CTRL)  done <= 1'b0;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_arg
        logic [31:0] r;
        always_ff @(posedge clk) begin
            if (!rstn) begin
                r <= '0;
            end else if (commit && wr_kind == K_ARG && aw_idx == 10'(ARG_BASE + g)) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb[b]) r[8*b +: 8] <= w_data[8*b +: 8];
            end
        end
        assign args[g] = r;
    end

    assign acc_args = args;

    always_comb begin
        rd_data = '0;
        case (rd_kind)
            K_CTRL: rd_data = {29'd0, busy, done, 1'b0};
            K_ARG: begin
                for (int i = 0; i < NREGS; i++)
                    if (ar_idx == 10'(ARG_BASE + i)) rd_data = args[i];
            end
            default: rd_data = '0;
        endcase
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axil_awaddr[31:12], s_axil_awaddr[1:0],
                                s_axil_araddr[31:12], s_axil_araddr[1:0]};
endmodule

// File: tb/tb_axil_acc_ctrl.sv
// Randomized bench for axil_acc_ctrl against a word-level register-map model.
module tb_axil_acc_ctrl;
    localparam int NREGS = 8;
    localparam int AW = 32 * NREGS;

    logic clk = 1'b0, rstn = 1'b0;
    logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic arvalid = 0, arready, rvalid, rready = 0;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
    logic [3:0]  wstrb = 0;
    logic [1:0]  bresp, rresp;
    logic        acc_start, acc_done = 0;
    logic [AW-1:0] acc_args;

    always #5 clk = ~clk;

    axil_acc_ctrl #(.NREGS(NREGS)) dut (
        .clk(clk), .rstn(rstn),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .acc_start(acc_start), .acc_done(acc_done), .acc_args(acc_args)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the register map as plain variables.
    logic [31:0] m_args[NREGS];
    logic        m_busy, m_done;

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_args[i] = 0;
        m_busy = 0;
        m_done = 0;
    endtask

    function automatic int m_kind(input logic [31:0] a);  // 0 rsvd, 1 ctrl, 2 arg, 3 bad
        int idx = int'(a[11:2]);
        if (idx == 0) return 0;
        if (idx == 1) return 1;
        if (idx >= 4 && idx < 4 + NREGS) return 2;
        return 3;
    endfunction

    function automatic logic [AW-1:0] m_pack();
        logic [AW-1:0] p;
        for (int i = 0; i < NREGS; i++) p[32*i +: 32] = m_args[i];
        return p;
    endfunction

    function automatic logic [31:0] m_read_val(input logic [31:0] a);
        int k = m_kind(a);
        if (k == 1) return {29'd0, m_busy, m_done, 1'b0};
        if (k == 2) return m_args[int'(a[11:2]) - 4];
        return 32'd0;
    endfunction

    // Entered and left at a negedge. skew>0: AW leads by skew cycles; skew<0: W leads.
    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int skew, input int bdly);
        int k = m_kind(a);
        int lag = (skew < 0) ? -skew : skew;
        logic [1:0] eb = (k == 3) ? 2'b10 : 2'b00;
        logic es = 0;
        if (k == 2) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_args[int'(a[11:2]) - 4][8*b +: 8] = d[8*b +: 8];
        end else if (k == 1 && s[0] && d[0] && !m_busy) begin
            es = 1; m_busy = 1; m_done = 0;
        end
        if (skew >= 0) begin awvalid = 1; awaddr = a; end
        if (skew <= 0) begin wvalid = 1; wdata = d; wstrb = s; end
        for (int i = 0; i < lag; i++) begin
            @(negedge clk);
            if (skew > 0) begin awvalid = 0; chk("awready_held", awready, 0); end
            else          begin wvalid = 0;  chk("wready_held", wready, 0); end
            chk("bvalid_wait", bvalid, 0);
        end
        if (skew > 0) begin wvalid = 1; wdata = d; wstrb = s; end
        if (skew < 0) begin awvalid = 1; awaddr = a; end
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("bvalid_early", bvalid, 0);
        @(negedge clk);
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, eb);
        chk("acc_start", acc_start, es);
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1);
            chk("wready_hold", wready, 0);
            chk("start_1cyc", acc_start, 0);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("bvalid_clr", bvalid, 0);
        chk("start_off", acc_start, 0);
        chk("awready_back", awready, 1);
        chk("acc_args", acc_args, m_pack());
    endtask

    task automatic axi_rd(input logic [31:0] a, input int rdly, input logic dpulse);
        logic [31:0] ed = m_read_val(a);
        logic [1:0]  er = (m_kind(a) == 3) ? 2'b10 : 2'b00;
        chk("arready_idle", arready, 1);
        arvalid = 1; araddr = a; acc_done = dpulse;
        @(negedge clk);
        arvalid = 0; acc_done = 0;
        if (m_kind(a) == 1) m_done = 0;
        if (dpulse) begin m_busy = 0; m_done = 1; end
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        chk("arready_busy", arready, 0);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, ed);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        chk("rvalid_clr", rvalid, 0);
    endtask

    task automatic done_pulse();
        acc_done = 1;
        @(negedge clk);
        acc_done = 0;
        m_busy = 0;
        m_done = 1;
    endtask

    initial begin
        logic [31:0] ed, r, a;
        int op, idx;
        m_reset();
        repeat (3) @(negedge clk);
        rstn = 1;
        @(negedge clk);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_start", acc_start, 0);
        chk("rst_args", acc_args, 0);
        chk("rst_rdata", rdata, 0);

        axi_wr(32'h018, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_rd(32'h018, 0, 0);
        axi_wr(32'h010, 32'h11223344, 4'b0101, -3, 1);
        chk("arg0_strb", acc_args[31:0], 32'h00220044);
        axi_wr(32'h004, 32'h1, 4'h1, 0, 0);
        axi_rd(32'h004, 0, 0);
        chk("ctrl_busy", rdata, 32'h4);
        axi_wr(32'h004, 32'h1, 4'h1, 2, 0);
        done_pulse();
        axi_rd(32'h004, 1, 0);
        chk("ctrl_done", rdata, 32'h2);
        axi_rd(32'h004, 0, 0);
        chk("ctrl_clr", rdata, 32'h0);
        axi_wr(32'h400, 32'hFFFFFFFF, 4'hF, 0, 0);
        axi_wr(32'h010 + 4 * NREGS, 32'hFFFFFFFF, 4'hF, 1, 0);
        axi_rd(32'h400, 0, 0);
        axi_rd(32'h010 + 4 * NREGS, 0, 0);
        axi_rd(32'h000, 0, 0);
        // Completion arriving with a CTRL read: read sees pre-pulse value.
        axi_wr(32'h004, 32'h1, 4'h1, 0, 1);
        axi_rd(32'h004, 0, 1);
        chk("ctrl_prepulse", rdata, 32'h4);
        axi_rd(32'h004, 0, 0);
        chk("ctrl_after", rdata, 32'h2);

        // Long rready stall, then reset during the stall.
        ed = m_read_val(32'h018);
        arvalid = 1; araddr = 32'h018;
        @(negedge clk);
        arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", rvalid, 1);
            chk("stall_rdata", rdata, ed);
            chk("stall_arready", arready, 0);
            @(negedge clk);
        end
        rstn = 0;
        @(negedge clk);
        m_reset();
        chk("rst_mid_rvalid", rvalid, 0);
        chk("rst_mid_args", acc_args, 0);
        rstn = 1;
        @(negedge clk);

        // Reset between handshake and commit: no start pulse, no response.
        awvalid = 1; awaddr = 32'h004; wvalid = 1; wdata = 32'h1; wstrb = 4'h1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; rstn = 0;
        @(negedge clk);
        chk("rst_wr_start", acc_start, 0);
        chk("rst_wr_bvalid", bvalid, 0);
        rstn = 1;
        @(negedge clk);
        chk("rst_wr_start2", acc_start, 0);
        chk("rst_wr_awready", awready, 1);

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            r = $urandom();
            case ($urandom_range(0, 7))
                0, 1, 2: idx = 4 + $urandom_range(0, NREGS - 1);
                3:       idx = 1;
                4:       idx = 0;
                5:       idx = $urandom_range(2, 3);
                default: idx = $urandom_range(4 + NREGS, 1023);
            endcase
            a = {r[31:12], 10'(idx), r[1:0]};
            if (op < 5)
                axi_wr(a, (idx == 1) ? {$urandom_range(0, 1) == 1 ? r : 32'h0} : $urandom(),
                       4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                       $urandom_range(0, 2));
            else if (op < 9)
                axi_rd(a, $urandom_range(0, 2), $urandom_range(0, 5) == 0);
            else
                done_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end
endmodule
